// File: rtl/idu1_sb_pkg.sv
// idu1_sb_pkg: shared types for the scoreboarded IDU1 stage.
// Decode bundles, FU indices and the hazard summary.
package idu1_sb_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam int FU_MUL = 0;
   localparam int FU_MAC = 1;
   localparam int FU_DIV = 2;
   localparam int FU_LSU = 3;
   localparam int NUM_FU = 4;

   typedef struct packed {
      logic [31:0]       pc;
      logic              legal;
      logic              nop;
      logic              rs1;
      logic              rs2;
      logic              rd;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic              mul;
      logic              mac;
      logic              div;
      logic              load;
      logic              store;
      logic [3:0]        alu_op;
   } idu0_out_t;

   typedef struct packed {
      idu0_out_t         dec;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
   } idu1_out_t;

   typedef struct packed {
      logic raw1;
      logic raw2;
      logic waw;
      logic structural;
   } idu1_sb_hazard_t;

   function automatic logic [NUM_FU-1:0] fu_need(idu0_out_t d);
      logic [NUM_FU-1:0] n;
      n = '0;
      n[FU_MUL] = d.mul;
      n[FU_MAC] = d.mac;
      n[FU_DIV] = d.div;
      n[FU_LSU] = d.load | d.store;
      return n;
   endfunction

endpackage

// File: rtl/idu1_sb_scoreboard.sv
// idu1_scoreboard: next-state and hazard lookup for pending rd bits.
// With IDU1_SB_WB_BYPASS_EN a same-cycle writeback masks its own bit.
module idu1_scoreboard #(
   parameter int NREGS = 32,
   localparam int AW = $clog2(NREGS)
) (
   input  logic [NREGS-1:0] pending,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             rs1_en,
   input  logic [AW-1:0]    rs1_addr,
   input  logic             rs2_en,
   input  logic [AW-1:0]    rs2_addr,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [NREGS-1:0] pending_nxt,
   output logic             raw1,
   output logic             raw2,
   output logic             waw
);

   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] eff;

   // one-hot of the writeback being retired this cycle
   always_comb begin
      clr_mask = '0;
      if (clr_en) clr_mask[clr_addr] = 1'b1;
   end

   // one-hot of the destination being issued this cycle
   always_comb begin
      set_mask = '0;
      if (set_en) set_mask[set_addr] = 1'b1;
   end

   // set wins over clear on the same index; x0 never pends
   always_comb begin
      pending_nxt = (pending & ~clr_mask) | set_mask;
      pending_nxt[0] = 1'b0;
   end

`ifdef IDU1_SB_WB_BYPASS_EN
   assign eff = pending & ~clr_mask;
`else
   assign eff = pending;
`endif

   assign raw1 = rs1_en & eff[rs1_addr];
   assign raw2 = rs2_en & eff[rs2_addr];
   assign waw  = rd_en & eff[rd_addr];

endmodule

// File: rtl/idu1_sb.sv
// idu1_sb: scoreboarded decode/issue stage between IDU0 and EXU.
// Define IDU1_SB_WB_BYPASS_EN for same-cycle writeback-to-issue bypass.
module idu1_sb
   import idu1_sb_pkg::*;
#(
   parameter int          XLEN = 32,
   parameter int          NREGS = 32,
   parameter logic [31:0] STACK_POINTER_INIT_VALUE = 32'h8000_0000,
   localparam int         AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  idu0_out_t        idu0_out,
   output idu1_out_t        idu1_out,
   output logic             issue_fire,
   output logic             pipe_stall,
   input  logic             pipe_flush,
   input  logic [XLEN-1:0]  exu_wb_data,
   input  logic [AW-1:0]    exu_wb_rd_addr,
   input  logic             exu_wb_rd_wr_en,
   input  logic [3:0]       fu_busy,
   input  logic             exu_lsu_stall,
   output logic [NREGS-1:0] sb_pending
);

   logic [XLEN-1:0]  rf [NREGS];
   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_nxt;
   idu1_out_t        q;
   idu1_out_t        q_d;
   idu1_sb_hazard_t  haz;

   logic            wb_live;
   logic [AW-1:0]   in_rs1_a;
   logic [AW-1:0]   in_rs2_a;
   logic            in_rs1_en;
   logic            in_rs2_en;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic [AW-1:0]   q_rs1_a;
   logic [AW-1:0]   q_rs2_a;
   logic [AW-1:0]   q_rd_a;
   logic            q_hit1;
   logic            q_hit2;
   logic            valid;
   logic            sb_set;

   assign wb_live   = exu_wb_rd_wr_en & (exu_wb_rd_addr != '0);
   assign in_rs1_a  = idu0_out.rs1_addr[AW-1:0];
   assign in_rs2_a  = idu0_out.rs2_addr[AW-1:0];
   assign in_rs1_en = idu0_out.rs1 & idu0_out.legal;
   assign in_rs2_en = idu0_out.rs2 & idu0_out.legal;

   // register file write port; x2 resets to the stack pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= (i == 2) ? XLEN'(STACK_POINTER_INIT_VALUE) : '0;
      end else if (wb_live) begin
         rf[exu_wb_rd_addr] <= exu_wb_data;
      end
   end

   // operand read with same-cycle writeback forwarding
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (in_rs1_en)
         rd1 = (wb_live && in_rs1_a == exu_wb_rd_addr) ? exu_wb_data : rf[in_rs1_a];
      if (in_rs2_en)
         rd2 = (wb_live && in_rs2_a == exu_wb_rd_addr) ? exu_wb_data : rf[in_rs2_a];
   end

   assign q_rs1_a = q.dec.rs1_addr[AW-1:0];
   assign q_rs2_a = q.dec.rs2_addr[AW-1:0];
   assign q_rd_a  = q.dec.rd_addr[AW-1:0];
   assign q_hit1  = q.dec.rs1 & wb_live & (q_rs1_a == exu_wb_rd_addr);
   assign q_hit2  = q.dec.rs2 & wb_live & (q_rs2_a == exu_wb_rd_addr);

   // load a new instruction, or refresh held operands while stalled
   always_comb begin
      q_d = q;
      if (!pipe_stall) begin
         q_d.dec      = idu0_out;
         q_d.rs1_data = rd1;
         q_d.rs2_data = rd2;
      end else begin
         if (q_hit1) q_d.rs1_data = exu_wb_data;
         if (q_hit2) q_d.rs2_data = exu_wb_data;
      end
   end

   // IDU1 register; flush beats load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          q <= '0;
      else if (pipe_flush) q <= '0;
      else                 q <= q_d;
   end

   assign valid  = q.dec.legal & ~q.dec.nop;
   assign sb_set = issue_fire & q.dec.rd & (q_rd_a != '0);

   idu1_scoreboard #(.NREGS(NREGS)) u_sb (
      .pending     (pending_q),
      .set_en      (sb_set),
      .set_addr    (q_rd_a),
      .clr_en      (exu_wb_rd_wr_en),
      .clr_addr    (exu_wb_rd_addr),
      .rs1_en      (q.dec.rs1),
      .rs1_addr    (q_rs1_a),
      .rs2_en      (q.dec.rs2),
      .rs2_addr    (q_rs2_a),
      .rd_en       (q.dec.rd),
      .rd_addr     (q_rd_a),
      .pending_nxt (pending_nxt),
      .raw1        (haz.raw1),
      .raw2        (haz.raw2),
      .waw         (haz.waw)
   );

   assign haz.structural = |(fu_need(q.dec) & fu_busy);

   assign pipe_stall = (valid & (|haz)) | exu_lsu_stall;
   assign issue_fire = valid & ~pipe_stall;

   // per-register pending state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_nxt;
   end

   assign sb_pending = pending_q;

   // issue bundle, zero unless issuing
   always_comb begin
      idu1_out = '0;
      if (issue_fire) begin
         idu1_out = q;
`ifdef IDU1_SB_WB_BYPASS_EN
         if (q_hit1) idu1_out.rs1_data = exu_wb_data;
         if (q_hit2) idu1_out.rs2_data = exu_wb_data;
`endif
      end
   end

endmodule

// File: tb/tb_idu1_sb.sv
// tb_idu1_sb: directed bench for idu1_sb with an issue scoreboard.
// Expected issue bundles are queued at drive time and popped on issue_fire.
module tb_idu1_sb;
   import idu1_sb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   idu0_out_t   idu0_out;
   idu1_out_t   idu1_out;
   logic        issue_fire;
   logic        pipe_stall;
   logic        pipe_flush;
   logic [31:0] exu_wb_data;
   logic [4:0]  exu_wb_rd_addr;
   logic        exu_wb_rd_wr_en;
   logic [3:0]  fu_busy;
   logic        exu_lsu_stall;
   logic [31:0] sb_pending;

`ifdef IDU1_SB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   idu1_out_t   expq[$];
   idu1_out_t   exp_e;
   logic [31:0] rf_m [32];

   idu1_sb dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .idu0_out        (idu0_out),
      .idu1_out        (idu1_out),
      .issue_fire      (issue_fire),
      .pipe_stall      (pipe_stall),
      .pipe_flush      (pipe_flush),
      .exu_wb_data     (exu_wb_data),
      .exu_wb_rd_addr  (exu_wb_rd_addr),
      .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
      .fu_busy         (fu_busy),
      .exu_lsu_stall   (exu_lsu_stall),
      .sb_pending      (sb_pending)
   );

   always #5 clk = ~clk;

   // kind: 0 alu, 1 mul, 2 div
   function automatic idu0_out_t mk(int kind, int rd, int r1, int r2);
      idu0_out_t d;
      d = '0;
      d.pc       = $urandom;
      d.legal    = 1'b1;
      d.rs1      = 1'b1;
      d.rs2      = 1'b1;
      d.rd       = 1'b1;
      d.rs1_addr = 5'(r1);
      d.rs2_addr = 5'(r2);
      d.rd_addr  = 5'(rd);
      d.mul      = (kind == 1);
      d.div      = (kind == 2);
      d.alu_op   = (kind == 0) ? 4'd1 : 4'd0;
      return d;
   endfunction

   function automatic idu1_out_t exp_of(idu0_out_t d, logic [31:0] a, logic [31:0] b);
      idu1_out_t e;
      e.dec      = d;
      e.rs1_data = a;
      e.rs2_data = b;
      return e;
   endfunction

   task automatic ck(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic wbdrv(int a, logic [31:0] v);
      exu_wb_rd_wr_en = 1'b1;
      exu_wb_rd_addr  = 5'(a);
      exu_wb_data     = v;
      if (a != 0) rf_m[a] = v;
   endtask

   task automatic wboff();
      exu_wb_rd_wr_en = 1'b0;
      exu_wb_rd_addr  = '0;
      exu_wb_data     = '0;
   endtask

   task automatic rf_reset();
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      rf_m[2] = 32'h8000_0000;
   endtask

   // pop and compare the expected bundle whenever the DUT issues
   always @(negedge clk) begin
      if (rst_n && issue_fire) begin
         checks++;
         assert (expq.size() != 0) else begin
            errors++;
            $error("FAIL issue_unexpected observed=%h expected=none", idu1_out);
         end
         if (expq.size() != 0) begin
            exp_e = expq.pop_front();
            checks++;
            assert (idu1_out === exp_e) else begin
               errors++;
               $error("FAIL issue_data observed=%h expected=%h", idu1_out, exp_e);
            end
         end
      end
   end

   initial begin
      idu0_out_t a, b;
      idu0_out = '0;
      pipe_flush = 1'b0;
      fu_busy = '0;
      exu_lsu_stall = 1'b1;
      wboff();
      rf_reset();

      #2;
      ck("rst_stall_lsu", 128'(pipe_stall), 128'(1'b1));
      ck("rst_issue", 128'(issue_fire), 128'(1'b0));
      ck("rst_out", 128'(idu1_out), 128'(0));
      ck("rst_pend", 128'(sb_pending), 128'(0));
      exu_lsu_stall = 1'b0;
      #1;
      ck("rst_stall", 128'(pipe_stall), 128'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      nx();

      wbdrv(1, 32'h11); nx();
      wbdrv(3, 32'h33); nx();
      wboff();

      // RAW: mul x5 then add x6,x5,x3
      a = mk(1, 5, 1, 2);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[2]));
      nx();
      b = mk(0, 6, 5, 3);
      idu0_out = b;
      @(negedge clk);
      ck("t1_mul_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t1_raw_stall", 128'(pipe_stall), 128'(1'b1));
      ck("t1_pend5", 128'(sb_pending), 128'(32'h20));
      ck("t1_out_zero", 128'(idu1_out), 128'(0));
      nx();
      @(negedge clk);
      ck("t1_hold", 128'(issue_fire), 128'(1'b0));
      nx();
      wbdrv(5, 32'h1234);
      expq.push_back(exp_of(b, 32'h1234, rf_m[3]));
      @(negedge clk);
      ck("t1_wb_cycle_fire", 128'(issue_fire), 128'(BYP));
      nx();
      wboff();
      @(negedge clk);
      ck("t1_wb1_cycle_fire", 128'(issue_fire), 128'(!BYP));
      nx();
      ck("t1_pend6", 128'(sb_pending), 128'(32'h40));
      wbdrv(6, 32'h66); nx();
      wboff();
      ck("t1_clear", 128'(sb_pending), 128'(0));

      // independent add behind a busy mul
      a = mk(1, 5, 1, 2);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[2]));
      nx();
      b = mk(0, 7, 1, 2);
      idu0_out = b;
      expq.push_back(exp_of(b, rf_m[1], rf_m[2]));
      @(negedge clk);
      ck("t2_mul_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      idu0_out = '0;
      fu_busy = 4'b0001;
      @(negedge clk);
      ck("t2_add_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      ck("t2_pend57", 128'(sb_pending), 128'(32'hA0));
      fu_busy = '0;
      wbdrv(5, 32'h55); nx();
      wbdrv(7, 32'h77); nx();
      wboff();
      ck("t2_clear", 128'(sb_pending), 128'(0));

      // structural hazard on the divider
      a = mk(2, 4, 1, 3);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[3]));
      nx();
      b = mk(2, 8, 3, 1);
      idu0_out = b;
      expq.push_back(exp_of(b, rf_m[3], rf_m[1]));
      @(negedge clk);
      ck("t3_div4_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      idu0_out = '0;
      fu_busy = 4'b0100;
      @(negedge clk);
      ck("t3_struct_stall", 128'(pipe_stall), 128'(1'b1));
      ck("t3_nofire", 128'(issue_fire), 128'(1'b0));
      nx();
      @(negedge clk);
      ck("t3_pend4", 128'(sb_pending), 128'(32'h10));
      nx();
      fu_busy = '0;
      @(negedge clk);
      ck("t3_div8_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      ck("t3_pend48", 128'(sb_pending), 128'(32'h110));
      wbdrv(4, 32'h44); nx();
      wbdrv(8, 32'h88); nx();
      wboff();

      // WAW on x5
      a = mk(1, 5, 1, 2);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[2]));
      nx();
      b = mk(0, 5, 1, 2);
      idu0_out = b;
      expq.push_back(exp_of(b, rf_m[1], rf_m[2]));
      @(negedge clk);
      ck("t4_mul_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t4_waw_stall", 128'(pipe_stall), 128'(1'b1));
      nx();
      wbdrv(5, 32'h5555);
      @(negedge clk);
      ck("t4_wb_cycle_fire", 128'(issue_fire), 128'(BYP));
      nx();
      wboff();
      @(negedge clk);
      ck("t4_wb1_cycle_fire", 128'(issue_fire), 128'(!BYP));
      ck("t4_pend5", 128'(sb_pending[5]), 128'(BYP));
      nx();
      ck("t4_pend5_kept", 128'(sb_pending), 128'(32'h20));

      // flush a held instruction stalled on x5
      a = mk(0, 9, 5, 1);
      idu0_out = a;
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t5_stall", 128'(pipe_stall), 128'(1'b1));
      ck("t5_out_zero", 128'(idu1_out), 128'(0));
      pipe_flush = 1'b1;
      nx();
      pipe_flush = 1'b0;
      @(negedge clk);
      ck("t5_flushed_stall", 128'(pipe_stall), 128'(1'b0));
      ck("t5_flushed_fire", 128'(issue_fire), 128'(1'b0));
      ck("t5_pend5", 128'(sb_pending), 128'(32'h20));
      nx();
      wbdrv(5, 32'h5a); nx();
      wboff();
      ck("t5_clear", 128'(sb_pending), 128'(0));

      // write to x0 never pends
      a = mk(0, 0, 1, 3);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[3]));
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t6_x0_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      ck("t6_pend0", 128'(sb_pending), 128'(0));

      // reset while stalled
      a = mk(1, 5, 1, 2);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[2]));
      nx();
      b = mk(0, 6, 5, 1);
      idu0_out = b;
      @(negedge clk);
      ck("t6_mul_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t6_stall", 128'(pipe_stall), 128'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      ck("t6_rst_pend", 128'(sb_pending), 128'(0));
      ck("t6_rst_stall", 128'(pipe_stall), 128'(1'b0));
      ck("t6_rst_fire", 128'(issue_fire), 128'(1'b0));
      ck("t6_rst_out", 128'(idu1_out), 128'(0));
      rf_reset();
      @(negedge clk);
      rst_n = 1'b1;
      nx();

      // register file back at reset values
      a = mk(0, 10, 1, 2);
      idu0_out = a;
      expq.push_back(exp_of(a, rf_m[1], rf_m[2]));
      nx();
      idu0_out = '0;
      @(negedge clk);
      ck("t7_fire", 128'(issue_fire), 128'(1'b1));
      nx();
      nx();

      ck("queue_empty", 128'(expq.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
